// File: rtl/reg8_wr_arbiter.sv
// Four-requester write arbiter/sequencer for a bank of four 8-bit registers.
// Define REG8_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module reg8_wr_arbiter #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2,
  output logic [7:0]  q3
);

  typedef enum logic [1:0] {StIdle, StWrite, StRelease} state_e;

  state_e      state_q, state_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  ptr_q;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  bank_q [4];
  logic [7:0]  bank_d [4];
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        wr_en;
  logic        req_w;
  logic [1:0]  w_addr;
  logic [7:0]  w_data;

  assign req_w  = req[win_q];
  assign w_addr = addr[{win_q, 1'b0} +: 2];
  assign w_data = wdata[{win_q, 3'b000} +: 8];

  // Winner search; iterating downward lets the smallest offset from ptr overwrite last.
  always_comb begin
    pick = 2'd0;
    idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) pick = idx;
    end
  end

`ifdef REG8_ARB_FIXED_PRI_EN
  assign ptr_q = 2'd0;
`else
  logic [1:0] ptr_d;

  // The pointer advances past the winner on every exit from WRITE, aborts included.
  assign ptr_d = (state_q == StWrite) ? win_q + 2'd1 : ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 2'd0;
    else      ptr_q <= ptr_d;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (|req) state_d = StWrite;
      StWrite:   state_d = req_w ? StRelease : StIdle;
      StRelease: if (!req_w) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Registered-output and datapath next values
  always_comb begin
    gnt_d = gnt_q;
    ack_d = ack_q;
    win_d = win_q;
    wr_en = 1'b0;
    case (state_q)
      StIdle: begin
        ack_d = 4'b0000;
        if (|req) begin
          gnt_d = 4'b0001 << pick;
          win_d = pick;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      StWrite: begin
        if (req_w) begin
          ack_d = 4'b0001 << win_q;
          wr_en = 1'b1;
        end else begin
          gnt_d = 4'b0000;
          ack_d = 4'b0000;
        end
      end
      StRelease: begin
        if (!req_w) begin
          gnt_d = 4'b0000;
          ack_d = 4'b0000;
        end
      end
      default: begin
        gnt_d = 4'b0000;
        ack_d = 4'b0000;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) bank_d[i] = bank_q[i];
    if (wr_en) bank_d[w_addr] = w_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= 4'b0000;
      ack_q <= 4'b0000;
      win_q <= 2'd0;
      for (int i = 0; i < 4; i++) bank_q[i] <= RST_VAL;
    end else begin
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      win_q <= win_d;
      for (int i = 0; i < 4; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != StIdle);
  assign q0   = bank_q[0];
  assign q1   = bank_q[1];
  assign q2   = bank_q[2];
  assign q3   = bank_q[3];

endmodule

// File: tb/tb_reg8_wr_arbiter.sv
// Self-checking bench for reg8_wr_arbiter: vector table, corner sequences, randomized transactions.
module tb_reg8_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  gnt, ack;
  logic        busy;
  logic [7:0]  q0, q1, q2, q3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mbank [4];
  int mptr;

  reg8_wr_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy),
    .q0    (q0),
    .q1    (q1),
    .q2    (q2),
    .q3    (q3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    int          ridx;
    logic [7:0]  val;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] qsel(input int i);
    case (i)
      0:       return q0;
      1:       return q1;
      2:       return q2;
      default: return q3;
    endcase
  endfunction

  task automatic chk_bank(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_q%0d", tag, i), qsel(i), mbank[i]);
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: first set bit scanning from the pointer (or from 0 in fixed mode).
  function automatic int winner(input logic [3:0] m, input int p);
`ifdef REG8_ARB_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) if (m[i]) return i;
`else
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
`endif
    return -1;
  endfunction

  task automatic do_reset();
    rst   = 1'b0;
    req   = 4'b0000;
    addr  = 8'h00;
    wdata = 32'h0;
    #3;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
    mptr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table of sequential single transactions starting from reset (ptr = 0).
    vecs[0] = '{4'b0100, 8'h30, 32'h00A5_0000, 4'b0100, 3, 8'hA5};
`ifdef REG8_ARB_FIXED_PRI_EN
    vecs[1] = '{4'b1111, 8'h55, 32'h1122_3344, 4'b0001, 1, 8'h44};
`else
    vecs[1] = '{4'b1111, 8'h55, 32'h1122_3344, 4'b1000, 1, 8'h11};
`endif
    vecs[2] = '{4'b1010, 8'hAA, 32'hDEAD_BEEF, 4'b0010, 2, 8'hBE};
    vecs[3] = '{4'b0011, 8'h00, 32'h7777_775A, 4'b0001, 0, 8'h5A};
    vecs[4] = '{4'b0001, 8'h03, 32'h0000_003C, 4'b0001, 3, 8'h3C};
`ifdef REG8_ARB_FIXED_PRI_EN
    vecs[5] = '{4'b1001, 8'h00, 32'hC300_00E1, 4'b0001, 0, 8'hE1};
`else
    vecs[5] = '{4'b1001, 8'h00, 32'hC300_00E1, 4'b1000, 0, 8'hC3};
`endif

    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_q%0d", i), qsel(i), 8'h00);
    #3;
    rst = 1'b1;

    // Vector table
    for (int v = 0; v < 6; v++) begin
      req   = vecs[v].req;
      addr  = vecs[v].addr;
      wdata = vecs[v].wdata;
      tick();
      chk($sformatf("vec%0d_gnt", v), gnt, vecs[v].gnt);
      chk($sformatf("vec%0d_busy", v), busy, 1'b1);
      tick();
      chk($sformatf("vec%0d_ack", v), ack, vecs[v].gnt);
      chk($sformatf("vec%0d_q", v), qsel(vecs[v].ridx), vecs[v].val);
      req = 4'b0000;
      tick();
      chk($sformatf("vec%0d_ack_off", v), ack, 4'b0000);
      chk($sformatf("vec%0d_gnt_off", v), gnt, 4'b0000);
      chk($sformatf("vec%0d_busy_off", v), busy, 1'b0);
    end

    // Reset asserted mid-RELEASE acts without a clock edge
    do_reset();
    req   = 4'b0100;
    addr  = 8'h30;
    wdata = 32'h00A5_0000;
    tick();
    tick();
    chk("mid_q3_written", q3, 8'hA5);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_ack", ack, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("mid_rst_q%0d", i), qsel(i), 8'h00);
    req = 4'b0001;
    #1;
    rst = 1'b1;
    tick();
    chk("post_rst_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    tick();

    // All four requesting; each drops req as soon as it sees its ack
    begin
      int order[$];
      int exp_order[5];
      logic [3:0] prev;
`ifdef REG8_ARB_FIXED_PRI_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      do_reset();
      prev  = 4'b0000;
      addr  = 8'hE4;
      wdata = 32'h4433_2211;
      req   = 4'b1111;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
        tick();
        if (gnt != 4'b0000 && prev == 4'b0000) order.push_back(oh2i(gnt));
        prev = gnt;
        req  = (ack != 4'b0000) ? (4'b1111 & ~ack) : 4'b1111;
      end
      chk("rr_grant_count", order.size(), 5);
      for (int i = 0; i < order.size() && i < 5; i++)
        chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
      req = 4'b0000;
      tick();
      tick();
    end

    // Abort: req[1] held for exactly one sampled edge
    do_reset();
    req   = 4'b0010;
    addr  = 8'h0C;
    wdata = 32'h0000_9900;
    tick();
    chk("abort_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    chk("abort_gnt_off", gnt, 4'b0000);
    chk("abort_ack", ack, 4'b0000);
    chk("abort_busy", busy, 1'b0);
    chk_bank("abort");
    req   = 4'b0011;
    addr  = 8'h00;
    wdata = 32'h0000_8877;
    tick();
    chk("abort_next_gnt", gnt, 4'b0001);
    tick();
    chk("abort_next_ack", ack, 4'b0001);
    chk("abort_next_q0", q0, 8'h77);
    req = 4'b0000;
    tick();

    // Randomized transactions against the transaction-level model
    do_reset();
    for (int t = 0; t < 80; t++) begin
      logic [3:0] m, oh, oth;
      int w, k;
      bit ab;
      m     = 4'($urandom_range(1, 15));
      addr  = 8'($urandom);
      wdata = $urandom;
      req   = m;
      w     = winner(m, mptr);
      oh    = 4'b0001 << w;
      tick();
      chk($sformatf("rnd%0d_gnt", t), gnt, oh);
      chk($sformatf("rnd%0d_busy", t), busy, 1'b1);
      chk($sformatf("rnd%0d_ack0", t), ack, 4'b0000);
      ab  = ($urandom_range(0, 3) == 0);
      oth = 4'($urandom) & ~oh;
      req = ab ? oth : (oth | oh);
      tick();
      mptr = (w + 1) % 4;
      if (ab) begin
        chk($sformatf("rnd%0d_ab_gnt", t), gnt, 4'b0000);
        chk($sformatf("rnd%0d_ab_ack", t), ack, 4'b0000);
        chk($sformatf("rnd%0d_ab_busy", t), busy, 1'b0);
        chk_bank($sformatf("rnd%0d_ab", t));
        req = 4'b0000;
      end else begin
        mbank[addr[2*w +: 2]] = wdata[8*w +: 8];
        chk($sformatf("rnd%0d_ack", t), ack, oh);
        chk_bank($sformatf("rnd%0d_wr", t));
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          req = (4'($urandom) & ~oh) | oh;
          tick();
          chk($sformatf("rnd%0d_hold_ack", t), ack, oh);
          chk($sformatf("rnd%0d_hold_gnt", t), gnt, oh);
        end
        req = 4'($urandom) & ~oh;
        tick();
        chk($sformatf("rnd%0d_rel_gnt", t), gnt, 4'b0000);
        chk($sformatf("rnd%0d_rel_ack", t), ack, 4'b0000);
        chk($sformatf("rnd%0d_rel_busy", t), busy, 1'b0);
        chk_bank($sformatf("rnd%0d_rel", t));
        req = 4'b0000;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
